// File: rtl/ppu_fetch_gen.sv
// ppu_fetch_gen: stands in for the 2C02 on the PPU bus. It walks the dot/line
// raster and issues the nametable, attribute, background pattern and sprite
// pattern fetches at NES dot timing, so that mapper snooping logic sees
// realistic bus traffic. Outputs describe the dot currently shown on dot/line.
module ppu_fetch_gen #(
   parameter int LINES     = 262,
   parameter int DOTS      = 341,
   parameter int VIS_LINES = 240,
   parameter int ODD_SKIP  = 1
) (
   input  logic        clk,
   input  logic        map_rst,
   input  logic        dot_ce,
   input  logic        bg_on,
   input  logic        spr_on,
   input  logic        bg_pt,
   input  logic        spr_pt,
   input  logic [14:0] scroll_t,
   input  logic [7:0]  ppu_din,
   output logic [13:0] ppu_addr,
   output logic        ppu_oe,
   output logic        vblank,
   output logic [8:0]  dot,
   output logic [8:0]  line
);

   localparam logic [8:0] DotLast    = 9'(DOTS - 1);
   localparam logic [8:0] SkipDot    = 9'(DOTS - 2);
   localparam logic [8:0] LineLast   = 9'(LINES - 1);
   localparam logic [8:0] VisLines   = 9'(VIS_LINES);
   localparam logic [8:0] VblankLine = 9'(VIS_LINES + 1);
   localparam logic       SkipEn     = (ODD_SKIP != 0);

   logic [8:0]  dot_q, dot_d;
   logic [8:0]  line_q, line_d;
   logic        odd_q, odd_d;
   logic [14:0] v_q, v_d;
   logic [7:0]  tile_q, tile_d;
   logic [13:0] addr_q, addr_d;
   logic        oe_q, oe_d;
   logic        vblank_q, vblank_d;

   logic render;
   logic curFetchLine;
   logic nextFetchLine;
   logic curBgWindow;
   logic nextBgWindow;

   assign render        = bg_on | spr_on;
   assign curFetchLine  = (line_q < VisLines) || (line_q == LineLast);
   assign nextFetchLine = (line_d < VisLines) || (line_d == LineLast);
   assign curBgWindow   = ((dot_q >= 9'd1) && (dot_q <= 9'd256)) ||
                          ((dot_q >= 9'd321) && (dot_q <= 9'd336));
   assign nextBgWindow  = ((dot_d >= 9'd1) && (dot_d <= 9'd256)) ||
                          ((dot_d >= 9'd321) && (dot_d <= 9'd336));

   // Raster position of the next dot, including the shortened pre-render
   // line on odd frames while rendering.
   always_comb begin
      dot_d  = dot_q;
      line_d = line_q;
      odd_d  = odd_q;
      if (SkipEn && render && odd_q && (line_q == LineLast) && (dot_q == SkipDot)) begin
         dot_d  = 9'd0;
         line_d = 9'd0;
         odd_d  = ~odd_q;
      end else if (dot_q == DotLast) begin
         dot_d = 9'd0;
         if (line_q == LineLast) begin
            line_d = 9'd0;
            odd_d  = ~odd_q;
         end else begin
            line_d = line_q + 9'd1;
         end
      end else begin
         dot_d = dot_q + 9'd1;
      end
   end

   // Vertical blank flag follows the position being entered, so it rises
   // exactly when dot 1 of the first vblank line is shown.
   always_comb begin
      vblank_d = vblank_q;
      if ((dot_d == 9'd1) && (line_d == VblankLine)) begin
         vblank_d = 1'b1;
      end
      if ((dot_d == 9'd1) && (line_d == LineLast)) begin
         vblank_d = 1'b0;
      end
   end

   // End-of-dot effects of the current dot: tile capture on the NT read
   // strobe (dots ending in 3'b010 of a background group) and the scroll
   // register increments/copies. Results feed the next dot's address.
   always_comb begin
      v_d    = v_q;
      tile_d = tile_q;
      if (render && curFetchLine) begin
         if (curBgWindow && (dot_q[2:0] == 3'd2)) begin
            tile_d = ppu_din;
         end
         if (((dot_q[2:0] == 3'd0) && (dot_q != 9'd0) && (dot_q <= 9'd256)) ||
             (dot_q == 9'd328) || (dot_q == 9'd336)) begin
            if (v_d[4:0] == 5'd31) begin
               v_d[4:0] = 5'd0;
               v_d[10]  = ~v_d[10];
            end else begin
               v_d[4:0] = v_d[4:0] + 5'd1;
            end
         end
         if (dot_q == 9'd256) begin
            if (v_d[14:12] != 3'd7) begin
               v_d[14:12] = v_d[14:12] + 3'd1;
            end else begin
               v_d[14:12] = 3'd0;
               if (v_d[9:5] == 5'd29) begin
                  v_d[9:5] = 5'd0;
                  v_d[11]  = ~v_d[11];
               end else if (v_d[9:5] == 5'd31) begin
                  v_d[9:5] = 5'd0;
               end else begin
                  v_d[9:5] = v_d[9:5] + 5'd1;
               end
            end
         end
         if (dot_q == 9'd257) begin
            v_d[10]  = scroll_t[10];
            v_d[4:0] = scroll_t[4:0];
         end
         if ((line_q == LineLast) && (dot_q >= 9'd280) && (dot_q <= 9'd304)) begin
            v_d[14:11] = scroll_t[14:11];
            v_d[9:5]   = scroll_t[9:5];
         end
      end
   end

   // Bus request for the next dot. Odd dots present a new address, even dots
   // keep it and pull the strobe low. Because every window starts on an odd
   // dot and 256 is a multiple of 8, dot[2:1] selects the slot in both the
   // background and sprite groups.
   always_comb begin
      addr_d = addr_q;
      oe_d   = 1'b1;
      if (render && nextFetchLine && (dot_d != 9'd0)) begin
         if (!dot_d[0]) begin
            oe_d = 1'b0;
         end else if (nextBgWindow) begin
            case (dot_d[2:1])
               2'd0:    addr_d = {2'b10, v_d[11:0]};
               2'd1:    addr_d = {2'b10, v_d[11:10], 4'b1111, v_d[9:7], v_d[4:2]};
               2'd2:    addr_d = {1'b0, bg_pt, tile_d, 1'b0, v_d[14:12]};
               default: addr_d = {1'b0, bg_pt, tile_d, 1'b1, v_d[14:12]};
            endcase
         end else if (dot_d <= 9'd320) begin
            case (dot_d[2:1])
               2'd2:    addr_d = {1'b0, spr_pt, 8'hFF, 1'b0, 3'b000};
               2'd3:    addr_d = {1'b0, spr_pt, 8'hFF, 1'b1, 3'b000};
               default: addr_d = {2'b10, v_d[11:0]};
            endcase
         end else begin
            addr_d = {2'b10, v_d[11:0]};
         end
      end
   end

   // All state advances together, one PPU dot per enabled clock.
   always_ff @(posedge clk or posedge map_rst) begin
      if (map_rst) begin
         dot_q    <= 9'd0;
         line_q   <= 9'd0;
         odd_q    <= 1'b0;
         v_q      <= 15'd0;
         tile_q   <= 8'd0;
         addr_q   <= 14'd0;
         oe_q     <= 1'b1;
         vblank_q <= 1'b0;
      end else if (dot_ce) begin
         dot_q    <= dot_d;
         line_q   <= line_d;
         odd_q    <= odd_d;
         v_q      <= v_d;
         tile_q   <= tile_d;
         addr_q   <= addr_d;
         oe_q     <= oe_d;
         vblank_q <= vblank_d;
      end
   end

   assign dot      = dot_q;
   assign line     = line_q;
   assign ppu_addr = addr_q;
   assign ppu_oe   = oe_q;
   assign vblank   = vblank_q;

endmodule

// File: tb/tb_ppu_fetch_gen.sv
// tb_ppu_fetch_gen: drives the fetch generator with directed and random
// stimulus and compares every dot against a field-level reference model.
// A short frame keeps run time small; the dot timing stays NES-exact.
module tb_ppu_fetch_gen;

   localparam int LINES = 12;
   localparam int DOTS  = 341;
   localparam int VIS   = 6;
   localparam int FULL  = LINES * DOTS;

   logic        clk = 1'b0;
   logic        mapRst = 1'b1;
   logic        dotCe = 1'b0;
   logic        bgOn = 1'b0;
   logic        sprOn = 1'b0;
   logic        bgPt = 1'b0;
   logic        sprPt = 1'b0;
   logic [14:0] scrollT = 15'd0;
   logic [7:0]  ppuDin = 8'd0;
   logic [13:0] ppuAddr;
   logic        ppuOe;
   logic        vblank;
   logic [8:0]  dot;
   logic [8:0]  line;

   int checkCount = 0;
   int passCount = 0;
   int oeLowCount = 0;

   // Reference model state: raster position, scroll fields, bus outputs
   int mDot, mLine, mOdd, mVblank, mAddr, mOe, mTile;
   int mFy, mCy, mCx, mNh, mNv;

   int expA[9] = '{32'h2000, 32'h2000, 32'h23C0, 32'h23C0, 32'h1420,
                   32'h1420, 32'h1428, 32'h1428, 32'h2001};

   ppu_fetch_gen #(
      .LINES(LINES),
      .DOTS(DOTS),
      .VIS_LINES(VIS),
      .ODD_SKIP(1)
   ) dut (
      .clk(clk),
      .map_rst(mapRst),
      .dot_ce(dotCe),
      .bg_on(bgOn),
      .spr_on(sprOn),
      .bg_pt(bgPt),
      .spr_pt(sprPt),
      .scroll_t(scrollT),
      .ppu_din(ppuDin),
      .ppu_addr(ppuAddr),
      .ppu_oe(ppuOe),
      .vblank(vblank),
      .dot(dot),
      .line(line)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (model line %0d dot %0d)",
                  tag, observed, expected, mLine, mDot);
      end
   endtask

   task automatic modelReset();
      mDot = 0; mLine = 0; mOdd = 0; mVblank = 0; mAddr = 0; mOe = 1; mTile = 0;
      mFy = 0; mCy = 0; mCx = 0; mNh = 0; mNv = 0;
   endtask

   function automatic int inBg(input int d);
      return (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
   endfunction

   function automatic int ntAddr();
      return 'h2000 + mNv * 2048 + mNh * 1024 + mCy * 32 + mCx;
   endfunction

   function automatic int atAddr();
      return 'h23C0 + mNv * 2048 + mNh * 1024 + (mCy / 4) * 8 + mCx / 4;
   endfunction

   task automatic incX();
      if (mCx == 31) begin
         mCx = 0;
         mNh = 1 - mNh;
      end else begin
         mCx = mCx + 1;
      end
   endtask

   task automatic incY();
      if (mFy < 7) begin
         mFy = mFy + 1;
      end else begin
         mFy = 0;
         if (mCy == 29) begin
            mCy = 0;
            mNv = 1 - mNv;
         end else if (mCy == 31) begin
            mCy = 0;
         end else begin
            mCy = mCy + 1;
         end
      end
   endtask

   // One PPU dot: finish the current dot, move on, then predict the bus
   task automatic stepModel();
      int render;
      int fl;
      int k;
      render = int'(bgOn | sprOn);
      fl = (mLine < VIS || mLine == LINES - 1) ? 1 : 0;
      if (render != 0 && fl != 0) begin
         if (inBg(mDot) != 0 && (mDot - 1) % 8 == 1) mTile = int'(ppuDin);
         if ((mDot >= 8 && mDot <= 256 && mDot % 8 == 0) || mDot == 328 || mDot == 336) incX();
         if (mDot == 256) incY();
         if (mDot == 257) begin
            mCx = int'(scrollT[4:0]);
            mNh = int'(scrollT[10]);
         end
         if (mLine == LINES - 1 && mDot >= 280 && mDot <= 304) begin
            mFy = int'(scrollT[14:12]);
            mCy = int'(scrollT[9:5]);
            mNv = int'(scrollT[11]);
         end
      end
      if (render != 0 && mLine == LINES - 1 && mDot == DOTS - 2 && mOdd == 1) begin
         mDot = 0; mLine = 0; mOdd = 0;
      end else if (mDot == DOTS - 1) begin
         mDot = 0;
         if (mLine == LINES - 1) begin
            mLine = 0;
            mOdd = 1 - mOdd;
         end else begin
            mLine = mLine + 1;
         end
      end else begin
         mDot = mDot + 1;
      end
      if (mDot == 1 && mLine == VIS + 1) mVblank = 1;
      if (mDot == 1 && mLine == LINES - 1) mVblank = 0;
      fl = (mLine < VIS || mLine == LINES - 1) ? 1 : 0;
      mOe = 1;
      if (render != 0 && fl != 0 && mDot != 0) begin
         if (mDot % 2 == 0) begin
            mOe = 0;
         end else if (inBg(mDot) != 0) begin
            k = ((mDot - 1) % 8) / 2;
            case (k)
               0: mAddr = ntAddr();
               1: mAddr = atAddr();
               2: mAddr = int'(bgPt) * 4096 + mTile * 16 + mFy;
               default: mAddr = int'(bgPt) * 4096 + mTile * 16 + 8 + mFy;
            endcase
         end else if (mDot <= 320) begin
            k = ((mDot - 257) % 8) / 2;
            if (k == 2) mAddr = int'(sprPt) * 4096 + 'hFF0;
            else if (k == 3) mAddr = int'(sprPt) * 4096 + 'hFF8;
            else mAddr = ntAddr();
         end else begin
            mAddr = ntAddr();
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("dot", int'(dot), mDot);
      checkOutput("line", int'(line), mLine);
      checkOutput("vblank", int'(vblank), mVblank);
      checkOutput("oe", int'(ppuOe), mOe);
      checkOutput("addr", int'(ppuAddr), mAddr);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (dotCe) stepModel();
      if (ppuOe == 1'b0) oeLowCount++;
      checkModel();
   endtask

   task automatic waitPos(input int l, input int d, input string tag);
      int n;
      n = 0;
      while (!(int'(line) == l && int'(dot) == d) && n < 3 * FULL) begin
         tick();
         n++;
      end
      checkOutput(tag, (int'(line) == l && int'(dot) == d) ? 1 : 0, 1);
   endtask

   task automatic runFrame(input string tag, input int expected);
      int n;
      int done;
      n = 0;
      done = 0;
      while (done == 0 && n < FULL + 10) begin
         tick();
         n++;
         if (dot == 9'd0 && line == 9'd0) done = 1;
      end
      checkOutput("frameEnd", done, 1);
      checkOutput(tag, n, expected);
   endtask

   task automatic applyStimulus();
      dotCe = ($urandom_range(0, 4) != 0);
      ppuDin = 8'($urandom);
      bgPt = 1'($urandom);
      sprPt = 1'($urandom);
      if ($urandom_range(0, 299) == 0) bgOn = ~bgOn;
      if ($urandom_range(0, 299) == 0) sprOn = ~sprOn;
      if ($urandom_range(0, 499) == 0) scrollT = 15'($urandom);
   endtask

   // Test sequence
   initial begin
      modelReset();
      #12;
      checkOutput("rstDot", int'(dot), 0);
      checkOutput("rstLine", int'(line), 0);
      checkOutput("rstOe", int'(ppuOe), 1);
      checkOutput("rstAddr", int'(ppuAddr), 0);
      checkOutput("rstVblank", int'(vblank), 0);

      bgOn = 1'b1; ppuDin = 8'h42; bgPt = 1'b1; sprPt = 1'b0; scrollT = 15'd0; dotCe = 1'b1;
      @(negedge clk);
      mapRst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         tick();
         checkOutput("l0Dot", int'(dot), i + 1);
         checkOutput("l0Addr", int'(ppuAddr), expA[i]);
         checkOutput("l0Oe", int'(ppuOe), (i % 2 == 0) ? 1 : 0);
      end

      waitPos(5, 261, "reachSpr");
      checkOutput("sprLo", int'(ppuAddr), 'h0FF0);
      tick();
      tick();
      checkOutput("sprHi", int'(ppuAddr), 'h0FF8);

      waitPos(5, 337, "reachEnd");
      checkOutput("endNt1", int'(ppuAddr), 'h2002);
      tick();
      checkOutput("endOe1", int'(ppuOe), 0);
      tick();
      checkOutput("endNt2", int'(ppuAddr), 'h2002);
      checkOutput("endDrv2", int'(ppuOe), 1);
      tick();
      checkOutput("endOe2", int'(ppuOe), 0);
      checkOutput("endHold2", int'(ppuAddr), 'h2002);

      waitPos(VIS + 1, 0, "reachVbOn");
      checkOutput("vbBefore", int'(vblank), 0);
      tick();
      checkOutput("vbSet", int'(vblank), 1);
      waitPos(LINES - 1, 0, "reachVbOff");
      checkOutput("vbHeld", int'(vblank), 1);
      tick();
      checkOutput("vbClr", int'(vblank), 0);

      waitPos(0, 0, "reachFrame");
      runFrame("oddFrameLen", FULL - 1);
      runFrame("evenFrameLen", FULL);

      for (int i = 0; i < 6000; i++) begin
         applyStimulus();
         tick();
      end

      dotCe = 1'b1; bgOn = 1'b0; sprOn = 1'b0;
      waitPos(0, 0, "reachOff");
      oeLowCount = 0;
      runFrame("offFrameLenA", FULL);
      runFrame("offFrameLenB", FULL);
      checkOutput("offOeLow", oeLowCount, 0);

      bgOn = 1'b1; ppuDin = 8'h5A; scrollT = 15'h73A0;
      waitPos(LINES - 1, 0, "reachPre29");
      waitPos(0, 1, "reachL0y29");
      checkOutput("y29Start", int'(ppuAddr), 'h23A2);
      waitPos(0, 321, "reachPf29");
      checkOutput("y29Wrap", int'(ppuAddr), 'h2800);

      scrollT = 15'h73E0;
      waitPos(LINES - 1, 0, "reachPre31");
      waitPos(0, 1, "reachL0y31");
      checkOutput("y31Start", int'(ppuAddr), 'h23E2);
      waitPos(0, 321, "reachPf31");
      checkOutput("y31Wrap", int'(ppuAddr), 'h2000);

      waitPos(9, 200, "reachMid");
      checkOutput("midVblank", int'(vblank), 1);
      #2;
      mapRst = 1'b1;
      #1;
      checkOutput("midRstDot", int'(dot), 0);
      checkOutput("midRstLine", int'(line), 0);
      checkOutput("midRstOe", int'(ppuOe), 1);
      checkOutput("midRstAddr", int'(ppuAddr), 0);
      checkOutput("midRstVblank", int'(vblank), 0);
      modelReset();
      scrollT = 15'd0;
      @(negedge clk);
      mapRst = 1'b0;
      tick();
      checkOutput("postRstNt", int'(ppuAddr), 'h2000);
      for (int i = 0; i < 20; i++) tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
